// File: rtl/result_requantizer.sv
// Requantizes signed accumulator results to unsigned DATA_WIDTH values through a
// 3-stage bias/scale/round pipeline feeding a small output FIFO with sticky overflow.
module result_requantizer #(
    parameter int RESULT_WIDTH  = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int INDEX_WIDTH   = 10,
    parameter int NEURON_AMOUNT = 4,
    parameter logic [RESULT_WIDTH*NEURON_AMOUNT-1:0] BIASES = '0,
    parameter logic [15:0] SCALE_MULT = 16'd16384,
    parameter int SCALE_SHIFT   = 15,
    parameter int OUTPUT_OFFSET = 0,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RESULT_WIDTH:0]   input_result,
    input  logic                    output_ready,
    output logic [DATA_WIDTH-1:0]   output_value,
    output logic [INDEX_WIDTH-1:0]  output_index,
    output logic                    output_enable,
    output logic                    overflow,
    output logic                    busy
);
    localparam int SW  = RESULT_WIDTH + 1;
    localparam int PW  = RESULT_WIDTH + 18;
    localparam int RWD = PW + 1;
    localparam int QW  = ((RWD > 32) ? RWD : 32) + 2;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic signed [RWD-1:0] HALF = (RWD'(1) << SCALE_SHIFT) >> 1;
    localparam logic signed [QW-1:0]  QMAX = QW'((64'sd1 << DATA_WIDTH) - 64'sd1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  value;
        logic [INDEX_WIDTH-1:0] index;
    } entry_t;

    logic [3:1]                     vld_pipe;
    logic [INDEX_WIDTH-1:0]         nidx, idx1, idx2;
    logic signed [SW-1:0]           sum1;
    logic signed [PW-1:0]           prod2;
    entry_t                         ent3;

    logic                           in_vld;
    logic signed [RESULT_WIDTH-1:0] in_acc, bias;
    logic signed [RWD-1:0]          rnd;
    logic signed [QW-1:0]           q;
    logic [DATA_WIDTH-1:0]          qc;

    assign in_vld = input_result[RESULT_WIDTH];
    assign in_acc = input_result[RESULT_WIDTH-1:0];
    assign bias   = BIASES[RESULT_WIDTH*nidx +: RESULT_WIDTH];

    // Round half up in a width that cannot overflow, then offset and clamp.
    always_comb begin
        rnd = (RWD'(prod2) + HALF) >>> SCALE_SHIFT;
        q   = QW'(rnd) + QW'(OUTPUT_OFFSET);
        qc  = q[DATA_WIDTH-1:0];
        if (q < 0)
            qc = '0;
        else if (q > QMAX)
            qc = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            nidx     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], in_vld};
            if (in_vld)
                nidx <= (nidx == INDEX_WIDTH'(NEURON_AMOUNT - 1)) ? '0 : nidx + 1'b1;
        end
    end

    // Data registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        sum1       <= SW'(in_acc) + SW'(bias);
        idx1       <= nidx;
        prod2      <= PW'(sum1) * PW'($signed({1'b0, SCALE_MULT}));
        idx2       <= idx1;
        ent3.value <= qc;
        ent3.index <= idx2;
    end

    entry_t         mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    count;
    logic           full, pop, push;

    assign full          = (count == (AW+1)'(FIFO_DEPTH));
    assign output_enable = (count != '0);
    assign pop           = output_enable && output_ready;
    assign push          = vld_pipe[3] && (!full || pop);
    assign output_value  = output_enable ? mem[rd_ptr].value : '0;
    assign output_index  = output_enable ? mem[rd_ptr].index : '0;
    assign busy          = (|vld_pipe) || output_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (vld_pipe[3] && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ent3;
    end
endmodule

// File: tb/tb_result_requantizer.sv
// Randomized bench for result_requantizer against a queue-based reference model.
module tb_result_requantizer;
    localparam int RW = 16, DW = 8, IW = 10, NA = 4, FD = 4;
    localparam logic [RW*NA-1:0] BIAS_P = {16'sd0, 16'sd0, 16'sd0, 16'sd10};

    logic          clk = 1'b0;
    logic          rst;
    logic [RW:0]   input_result;
    logic          output_ready;
    logic [DW-1:0] output_value;
    logic [IW-1:0] output_index;
    logic          output_enable, overflow, busy;

    always #5 clk = ~clk;

    result_requantizer #(
        .RESULT_WIDTH(RW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .NEURON_AMOUNT(NA),
        .BIASES(BIAS_P), .SCALE_MULT(16'd16384), .SCALE_SHIFT(15),
        .OUTPUT_OFFSET(0), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .input_result(input_result), .output_ready(output_ready),
        .output_value(output_value), .output_index(output_index),
        .output_enable(output_enable), .overflow(overflow), .busy(busy)
    );

    typedef struct { int due; int val; int idx; } pend_t;
    typedef struct { int val; int idx; } ent_t;

    pend_t pend[$];
    ent_t  fifo_m[$];
    int    cyc, n_m;
    bit    ovf_m;
    int    vectors, miscompares;
    int    bias_m[NA] = '{10, 0, 0, 0};

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Expected output from plain integer arithmetic: bias, scale, round half up, clamp.
    function automatic int ref_q(int x, int n);
        longint s, p, r;
        s = longint'(x) + longint'(bias_m[n]);
        p = s * 16384;
        r = (p + 16384) >>> 15;
        if (r < 0) return 0;
        if (r > 255) return 255;
        return int'(r);
    endfunction

    // One cycle: inputs are already driven; check outputs mid-cycle, then advance the model.
    task automatic cycle(input bit r, input bit v, input int x, input bit rdy);
        bit pop, bsy;
        pend_t p;
        rst = r;
        input_result = {v, RW'(x)};
        output_ready = rdy;
        @(negedge clk);
        bsy = (fifo_m.size() != 0) || (pend.size() != 0 && pend[0].due - 2 <= cyc);
        chk("enable", longint'(output_enable), longint'(fifo_m.size() != 0));
        chk("value", longint'(output_value), fifo_m.size() != 0 ? fifo_m[0].val : 0);
        chk("index", longint'(output_index), fifo_m.size() != 0 ? fifo_m[0].idx : 0);
        chk("overflow", longint'(overflow), longint'(ovf_m));
        chk("busy", longint'(busy), longint'(bsy));
        @(posedge clk);
        if (r) begin
            pend.delete();
            fifo_m.delete();
            n_m = 0;
            ovf_m = 0;
        end else begin
            pop = (fifo_m.size() != 0) && rdy;
            if (pop) void'(fifo_m.pop_front());
            if (pend.size() != 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                if (fifo_m.size() < FD) fifo_m.push_back('{p.val, p.idx});
                else ovf_m = 1;
            end
            if (v) begin
                pend.push_back('{cyc + 3, ref_q(x, n_m), n_m});
                n_m = (n_m + 1) % NA;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int mode, x;
        bit v, rdy, r;
        vectors = 0; miscompares = 0; cyc = 0; n_m = 0; ovf_m = 0;
        rst = 1'b1; input_result = '0; output_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        // Single result: 100 + bias 10 scaled by 1/2 -> 55 four cycles later.
        cycle(0, 1, 100, 1);
        repeat (3) cycle(0, 0, 0, 1);
        chk("single_en", longint'(output_enable), 1);
        chk("single_val", longint'(output_value), 55);
        chk("single_idx", longint'(output_index), 0);
        cycle(0, 0, 0, 1);
        chk("single_busy", longint'(busy), 0);

        // Rounding and clamping, then a backpressure burst that overflows.
        cycle(0, 1, 101, 1); cycle(0, 1, -300, 1); cycle(0, 1, 1000, 1);
        repeat (6) cycle(0, 0, 0, 1);
        repeat (5) cycle(0, 1, 2, 0);
        repeat (6) cycle(0, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 1);

        // Reset mid-flight, then confirm the next input starts at index 0.
        cycle(0, 1, 50, 1); cycle(0, 1, 60, 1); cycle(1, 1, 70, 1);
        repeat (5) cycle(0, 0, 0, 1);
        cycle(0, 1, 7, 1);
        repeat (4) cycle(0, 0, 0, 1);

        for (int ph = 0; ph < 80; ph++) begin
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 40; i++) begin
                case (mode)
                    0: rdy = 1;
                    1: rdy = 0;
                    2: rdy = ($urandom_range(0, 1) == 1);
                    default: rdy = ($urandom_range(0, 3) != 0);
                endcase
                v = (mode == 3) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 3) == 0)
                    x = int'($signed(RW'($urandom)));
                else
                    x = $urandom_range(0, 700) - 300;
                r = ($urandom_range(0, 99) == 0);
                cycle(r, v, x, rdy);
            end
        end
        repeat (8) cycle(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/result_requantizer.md
RESULT_REQUANTIZER -- requirements
Module: result_requantizer

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- RESULT_WIDTH, 16, accumulator width of the upstream result bus.
- DATA_WIDTH, 8, quantized output width.
- INDEX_WIDTH, 10, neuron index width.
- NEURON_AMOUNT, 4, results per layer pass; neuron counter wraps here.
- BIASES, all zero, RESULT_WIDTH*NEURON_AMOUNT bits; signed bias n at slice [RESULT_WIDTH*n +: RESULT_WIDTH].
- SCALE_MULT, 16384, unsigned 16-bit fixed-point multiplier.
- SCALE_SHIFT, 15, right shift applied after the multiply (0..31).
- OUTPUT_OFFSET, 0, signed zero point added after the shift.
- FIFO_DEPTH, 4, output buffer entries (power of two, at least 2).

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on the rising edge.
- rst, in, 1, synchronous active-high reset.
- input_result, in, RESULT_WIDTH+1, bit RESULT_WIDTH is the valid flag; the low bits are a signed accumulator.
- output_ready, in, 1, consumer accepts the head entry.
- output_value, out, DATA_WIDTH, quantized unsigned result.
- output_index, out, INDEX_WIDTH, neuron number of output_value.
- output_enable, out, 1, head entry valid (FIFO not empty).
- overflow, out, 1, sticky flag: a result was dropped.
- busy, out, 1, any pipeline stage valid or FIFO not empty.

Function
REQ-003 SHALL treat input_result as one result per cycle when bit RESULT_WIDTH=1; there is no input backpressure.
REQ-004 SHALL tag each accepted result with neuron counter n (0..NEURON_AMOUNT-1), then increment n, wrapping NEURON_AMOUNT-1 -> 0.
REQ-005 Stage 1 (cycle 1) SHALL register sum = sign-extended result + sign-extended BIASES[n], RESULT_WIDTH+1 bits signed, with no saturation.
REQ-006 Stage 2 (cycle 2) SHALL register prod = sum * SCALE_MULT, signed, RESULT_WIDTH+18 bits.
REQ-007 Stage 3 (cycle 3) SHALL compute:
- r = (prod + (SCALE_SHIFT>0 ? 2^(SCALE_SHIFT-1) : 0)) >>> SCALE_SHIFT (arithmetic shift, round half up).
- q = r + OUTPUT_OFFSET.
- Clamp q to [0, 2^DATA_WIDTH-1].
- Register q with its index.
REQ-008 Stage 3 valid SHALL push {q, index} into the FIFO at the end of cycle 3; the entry is visible at the head in cycle 4, giving 4-cycle latency when the FIFO is empty.
REQ-009 The head entry SHALL be popped on any edge where output_enable=1 and output_ready=1; entries leave in push order.
REQ-010 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-011 A push to a full FIFO with no pop SHALL discard the entry, leave the FIFO unchanged, and set overflow=1 until reset.
REQ-012 When output_enable=0, output_value and output_index SHALL be 0.
REQ-013 The pipeline SHALL advance every cycle regardless of output_ready; stage valid bits travel with the data.
REQ-014 A simultaneous push and pop on an empty FIFO SHALL be impossible, because the pop requires output_enable=1.
REQ-015 busy SHALL equal the OR of the three stage valid bits and FIFO-not-empty.

Reset
REQ-016 When rst=1 at an edge, the block SHALL:
- clear all stage valid bits;
- empty the FIFO (pointers and count to 0);
- set the neuron counter to 0;
- clear overflow;
- drive output_value, output_index, output_enable and busy to 0 from the next cycle.
REQ-017 A reset during operation SHALL discard all in-flight and buffered results; a result presented in the same cycle as rst=1 SHALL be ignored.
REQ-018 The first valid input after reset is released SHALL receive index 0.

Verification (defaults, BIASES[0]=10, others 0, output_ready=1)
REQ-019 Single result: input 100 with valid, cycle 0 -> cycle 4: output_enable=1, value 55, index 0; busy=0 after the pop.
REQ-020 Rounding and clamping, at index 1: input 101 -> 51; input -300 -> 0; input 1000 -> 255.
REQ-021 Wrap: five back-to-back valid inputs of value 2 -> indices 0,1,2,3,0; values 6,1,1,1,6.
REQ-022 Backpressure: output_ready=0, five consecutive results -> four entries held, fifth dropped, overflow=1; then output_ready=1 -> the four drain in order over 4 cycles; overflow stays 1.
REQ-023 Full with pop: FIFO full and a push coinciding with a pop -> count stays 4, no drop, overflow stays 0.
REQ-024 Reset mid-flight: rst=1 in cycle 2 after inputs in cycles 0 and 1 -> no output_enable ever; busy=0; the next input gets index 0.
